// File: rtl/result_bram_writer_if.sv
// Result stream and BRAM write port bundle for result_bram_writer.
// The master modport is the stream source and BRAM observer; the slave modport is the writer.
interface result_bram_writer_if #(
  parameter int DATA_WIDTH_RSLT = 16,
  parameter int KEEP_WIDTH      = (DATA_WIDTH_RSLT + 7) / 8,
  parameter int ADDR_WIDTH      = 32
);
  logic [DATA_WIDTH_RSLT-1:0] s_axis_rslt_tdata;
  logic [KEEP_WIDTH-1:0]      s_axis_rslt_tkeep;
  logic                       s_axis_rslt_tvalid;
  logic                       s_axis_rslt_tready;
  logic                       s_axis_rslt_tlast;
  logic                       rslt_bram_en;
  logic [KEEP_WIDTH-1:0]      rslt_bram_we;
  logic [ADDR_WIDTH-1:0]      rslt_bram_addr;
  logic [DATA_WIDTH_RSLT-1:0] rslt_bram_wrdata;

  modport master (
    output s_axis_rslt_tdata, s_axis_rslt_tkeep, s_axis_rslt_tvalid, s_axis_rslt_tlast,
    input  s_axis_rslt_tready,
    input  rslt_bram_en, rslt_bram_we, rslt_bram_addr, rslt_bram_wrdata
  );

  modport slave (
    input  s_axis_rslt_tdata, s_axis_rslt_tkeep, s_axis_rslt_tvalid, s_axis_rslt_tlast,
    output s_axis_rslt_tready,
    output rslt_bram_en, rslt_bram_we, rslt_bram_addr, rslt_bram_wrdata
  );
endinterface

// File: rtl/result_bram_writer.sv
// Writes an AXI-Stream result channel into BRAM at sequential addresses from a latched base.
// Optional macro RSLT_WRITER_STRICT_TLAST_EN: tlast must coincide with the final counted beat.
module result_bram_writer #(
  parameter int DATA_WIDTH_RSLT = 16,
  parameter bit KEEP_ENABLE     = (DATA_WIDTH_RSLT > 8),
  parameter int KEEP_WIDTH      = (DATA_WIDTH_RSLT + 7) / 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int SIZE_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  result_bram_writer_if.slave   rif,
  input  logic                  operation_start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [SIZE_WIDTH-1:0] rslt_size,
  output logic                  operation_in_progress,
  output logic                  operation_complete,
  output logic                  operation_error,
  output logic [SIZE_WIDTH-1:0] words_written
);
  localparam int BYTES = DATA_WIDTH_RSLT / 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  state_t                     state_q, state_d;
  logic [SIZE_WIDTH-1:0]      size_q, size_d;
  logic [SIZE_WIDTH-1:0]      cnt_q, cnt_d;
  logic [SIZE_WIDTH-1:0]      words_q, words_d;
  logic [ADDR_WIDTH-1:0]      wptr_q, wptr_d;
  logic                       en_q, en_d;
  logic [KEEP_WIDTH-1:0]      we_q, we_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH_RSLT-1:0] wrdata_q, wrdata_d;
  logic                       accept;
  logic                       last_beat;

  assign accept    = rif.s_axis_rslt_tvalid && (state_q == RUN);
  assign last_beat = (cnt_q == size_q - SIZE_WIDTH'(1));

`ifndef RSLT_WRITER_STRICT_TLAST_EN
  logic unused_tlast;
  assign unused_tlast = rif.s_axis_rslt_tlast;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      size_q   <= '0;
      cnt_q    <= '0;
      words_q  <= '0;
      wptr_q   <= '0;
      en_q     <= 1'b0;
      we_q     <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      words_q  <= words_d;
      wptr_q   <= wptr_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    words_d  = words_q;
    wptr_d   = wptr_q;
    // BRAM port registers one accepted beat; idle cycles drop en and we.
    en_d     = accept;
    we_d     = '0;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    if (accept) begin
      we_d     = KEEP_ENABLE ? rif.s_axis_rslt_tkeep : {KEEP_WIDTH{1'b1}};
      addr_d   = wptr_q;
      wrdata_d = rif.s_axis_rslt_tdata;
    end

    unique case (state_q)
      IDLE: begin
        if (operation_start) begin
          size_d  = rslt_size;
          cnt_d   = '0;
          words_d = '0;
          wptr_d  = base_addr;
          state_d = (rslt_size != '0) ? RUN : ERR;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d   = cnt_q + SIZE_WIDTH'(1);
          words_d = words_q + SIZE_WIDTH'(1);
          // Pointer wraps modulo 2^ADDR_WIDTH by plain truncation.
          wptr_d  = wptr_q + ADDR_WIDTH'(BYTES);
`ifdef RSLT_WRITER_STRICT_TLAST_EN
          if (last_beat)
            state_d = rif.s_axis_rslt_tlast ? DONE : ERR;
          else if (rif.s_axis_rslt_tlast)
            state_d = ERR;
`else
          if (last_beat)
            state_d = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rif.s_axis_rslt_tready = (state_q == RUN);
  assign rif.rslt_bram_en       = en_q;
  assign rif.rslt_bram_we       = we_q;
  assign rif.rslt_bram_addr     = addr_q;
  assign rif.rslt_bram_wrdata   = wrdata_q;

  assign operation_in_progress = (state_q == RUN);
  assign operation_complete    = (state_q == DONE);
  assign operation_error       = (state_q == ERR);
  assign words_written         = words_q;
endmodule

// File: tb/tb_result_bram_writer.sv
// Directed bench for result_bram_writer; a second instance with KEEP_ENABLE=0 shadows the stream.
module tb_result_bram_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        operation_start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] rslt_size = '0;
  logic        in_prog, complete, error;
  logic [31:0] words;
  logic        in_prog2, complete2, error2;
  logic [31:0] words2;
  logic [31:0] cur_base;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  result_bram_writer_if #(.DATA_WIDTH_RSLT(16), .KEEP_WIDTH(2), .ADDR_WIDTH(32)) rif ();
  result_bram_writer_if #(.DATA_WIDTH_RSLT(16), .KEEP_WIDTH(2), .ADDR_WIDTH(32)) rif2 ();

  assign rif2.s_axis_rslt_tdata  = rif.s_axis_rslt_tdata;
  assign rif2.s_axis_rslt_tkeep  = rif.s_axis_rslt_tkeep;
  assign rif2.s_axis_rslt_tvalid = rif.s_axis_rslt_tvalid;
  assign rif2.s_axis_rslt_tlast  = rif.s_axis_rslt_tlast;

  result_bram_writer #(.DATA_WIDTH_RSLT(16)) dut (
    .clk(clk), .rst_n(rst_n), .rif(rif),
    .operation_start(operation_start), .base_addr(base_addr), .rslt_size(rslt_size),
    .operation_in_progress(in_prog), .operation_complete(complete),
    .operation_error(error), .words_written(words)
  );

  result_bram_writer #(.DATA_WIDTH_RSLT(16), .KEEP_ENABLE(1'b0)) dut_nokeep (
    .clk(clk), .rst_n(rst_n), .rif(rif2),
    .operation_start(operation_start), .base_addr(base_addr), .rslt_size(rslt_size),
    .operation_in_progress(in_prog2), .operation_complete(complete2),
    .operation_error(error2), .words_written(words2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] b, input logic [31:0] n);
    operation_start = 1'b1;
    base_addr       = b;
    rslt_size       = n;
    cur_base        = b;
    tick();
    operation_start = 1'b0;
  endtask

  // Drives beats first..first+n-1; each beat's write is checked the cycle after acceptance.
  task automatic drive_run(input int first, input int n, input bit gap,
                           input int keep_beat, input logic [1:0] keep_val, input int last_idx);
    for (int i = first; i < first + n; i++) begin
      logic [31:0] ea;
      logic [1:0]  ek;
      if (gap && i > first) begin
        rif.s_axis_rslt_tvalid = 1'b0;
        tick();
        chk("gap_en", rif.rslt_bram_en, 1'b0);
        chk("gap_we", rif.rslt_bram_we, 2'b00);
        chk("gap_inprog", in_prog, 1'b1);
      end
      ek = (i == keep_beat) ? keep_val : 2'b11;
      rif.s_axis_rslt_tvalid = 1'b1;
      rif.s_axis_rslt_tdata  = 16'h00A1 + 16'(i);
      rif.s_axis_rslt_tkeep  = ek;
      rif.s_axis_rslt_tlast  = (i == last_idx);
      tick();
      ea = cur_base + 32'(2 * i);
      chk("wr_en", rif.rslt_bram_en, 1'b1);
      chk("wr_addr", rif.rslt_bram_addr, ea);
      chk("wr_data", rif.rslt_bram_wrdata, 16'h00A1 + 16'(i));
      chk("wr_we", rif.rslt_bram_we, ek);
      chk("wr_we_nokeep", rif2.rslt_bram_we, 2'b11);
    end
    rif.s_axis_rslt_tvalid = 1'b0;
    rif.s_axis_rslt_tlast  = 1'b0;
  endtask

  initial begin
    rif.s_axis_rslt_tdata  = '0;
    rif.s_axis_rslt_tkeep  = '0;
    rif.s_axis_rslt_tvalid = 1'b0;
    rif.s_axis_rslt_tlast  = 1'b0;
    cur_base = '0;
    #12;
    chk("rst_tready", rif.s_axis_rslt_tready, 1'b0);
    chk("rst_tready2", rif2.s_axis_rslt_tready, 1'b0);
    chk("rst_en", rif.rslt_bram_en, 1'b0);
    chk("rst_we", rif.rslt_bram_we, 2'b00);
    chk("rst_addr", rif.rslt_bram_addr, 32'h0);
    chk("rst_flags", {in_prog, complete, error}, 3'b000);
    chk("rst_words", words, 32'h0);
    rst_n = 1'b1;
    tick();

    // Back-to-back run, then start held through DONE must be ignored until IDLE.
    start_run(32'h100, 32'd4);
    chk("t1_inprog", in_prog, 1'b1);
    chk("t1_tready", rif.s_axis_rslt_tready, 1'b1);
    drive_run(0, 4, 1'b0, -1, 2'b11, 3);
    chk("t1_complete", complete, 1'b1);
    chk("t1_words", words, 32'd4);
    chk("t1_tready_done", rif.s_axis_rslt_tready, 1'b0);
    operation_start = 1'b1; base_addr = 32'h700; rslt_size = 32'd1; cur_base = 32'h700;
    tick();
    chk("t1_done_pulse_end", complete, 1'b0);
    chk("t1_start_ignored", in_prog, 1'b0);
    chk("t1_idle_en", rif.rslt_bram_en, 1'b0);
    tick();
    operation_start = 1'b0;
    chk("t1_start_taken", in_prog, 1'b1);
    chk("t1_words_clr", words, 32'd0);
    drive_run(0, 1, 1'b0, -1, 2'b11, 0);
    chk("t1b_complete", complete, 1'b1);
    tick();

    // Gapped run.
    start_run(32'h200, 32'd4);
    drive_run(0, 4, 1'b1, -1, 2'b11, 3);
    chk("t2_complete", complete, 1'b1);
    chk("t2_words", words, 32'd4);
    tick();
    chk("t2_pulse_once", complete, 1'b0);

    // Size zero.
    start_run(32'h300, 32'd0);
    chk("t3_error", error, 1'b1);
    chk("t3_en", rif.rslt_bram_en, 1'b0);
    chk("t3_inprog", in_prog, 1'b0);
    tick();
    chk("t3_error_once", error, 1'b0);
    chk("t3_en2", rif.rslt_bram_en, 1'b0);

    // Early tlast on beat 2.
    start_run(32'h400, 32'd4);
    drive_run(0, 2, 1'b0, -1, 2'b11, 1);
`ifdef RSLT_WRITER_STRICT_TLAST_EN
    chk("t4_error", error, 1'b1);
    chk("t4_inprog", in_prog, 1'b0);
    chk("t4_words", words, 32'd2);
    tick();
    chk("t4_error_once", error, 1'b0);
`else
    chk("t4_no_error", error, 1'b0);
    chk("t4_inprog", in_prog, 1'b1);
    drive_run(2, 2, 1'b0, -1, 2'b11, 3);
    chk("t4_complete", complete, 1'b1);
    chk("t4_words", words, 32'd4);
    tick();
`endif

    // Partial tkeep on beat 2.
    start_run(32'h500, 32'd3);
    drive_run(0, 3, 1'b0, 1, 2'b01, 2);
    chk("t5_complete", complete, 1'b1);
    tick();

    // Reset mid-run, then a run whose addresses wrap.
    start_run(32'h600, 32'd4);
    drive_run(0, 2, 1'b0, -1, 2'b11, 3);
    rif.s_axis_rslt_tvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_tready", rif.s_axis_rslt_tready, 1'b0);
    chk("t6_en", rif.rslt_bram_en, 1'b0);
    chk("t6_flags", {in_prog, complete, error}, 3'b000);
    chk("t6_words", words, 32'd0);
    rif.s_axis_rslt_tvalid = 1'b0;
    tick();
    chk("t6_no_pulse", {complete, error}, 2'b00);
    rst_n = 1'b1;
    tick();
    start_run(32'hFFFF_FFFE, 32'd2);
    drive_run(0, 2, 1'b0, -1, 2'b11, 1);
    chk("t6_complete", complete, 1'b1);
    chk("t6_words2", words, 32'd2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
